// File: rtl/seed_random_deck_dealer.sv
// Rank-only card source: draws 1..13 without replacement from a multi-deck shoe,
// using a free-running Fibonacci LFSR whose phase at request time supplies entropy.
module seed_random_deck_dealer #(
  parameter int unsigned LFSR_W    = 16,
  parameter logic [31:0] SEED      = 32'h0000_ACE1,
  parameter int unsigned NUM_DECKS = 1,
  parameter int unsigned CARD_W    = 8,
  parameter int unsigned CNT_W     = $clog2(52 * NUM_DECKS + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              request_card_i,
  input  logic              shuffle_i,
  output logic [CARD_W-1:0] card_to_send_o,
  output logic              card_valid_o,
  output logic              busy_o,
  output logic              deck_empty_o,
  output logic [CNT_W-1:0]  cards_left_o
);

  localparam int unsigned       NUM_RANKS = 13;
  localparam int unsigned       RANK_W    = $clog2(4 * NUM_DECKS + 1);
  localparam logic [RANK_W-1:0] PER_RANK  = RANK_W'(4 * NUM_DECKS);
  localparam logic [CNT_W-1:0]  FULL_SHOE = CNT_W'(52 * NUM_DECKS);

  // Feedback tap masks (tap n maps to bit n-1); unsupported widths fall back to 16-bit taps.
  localparam logic [31:0] TAP_ALL = (LFSR_W == 8)  ? 32'h0000_00B8 :
                                    (LFSR_W == 24) ? 32'h00E1_0000 :
                                    (LFSR_W == 32) ? 32'h8020_0003 :
                                                     32'h0000_B400;
  localparam logic [LFSR_W-1:0] TAPS   = LFSR_W'(TAP_ALL);
  localparam logic [LFSR_W-1:0] SEED_T = LFSR_W'(SEED);
  localparam logic [LFSR_W-1:0] SEED_V = (SEED_T == '0) ? LFSR_W'(1) : SEED_T;

  typedef enum logic [1:0] {IDLE, SAMPLE, PROBE, DEAL} state_t;

  state_t            state;
  logic [LFSR_W-1:0] lfsr;
  logic              req_s;
  logic              req_q;
  logic              req_edge;
  logic [3:0]        idx;
  logic [3:0]        r_raw;
  logic [3:0]        r_mod;
  logic [RANK_W-1:0] count [NUM_RANKS];
  logic [CNT_W-1:0]  sum_c;

  function automatic logic [3:0] next_rank(input logic [3:0] i);
    return (i == 4'd12) ? 4'd0 : i + 4'd1;
  endfunction

  // Free-running LFSR, independent of the draw state.
  always_ff @(posedge clk_i) begin
    if (!rst_i) lfsr <= SEED_V;
    else        lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
  end

  // Request is registered once, then edge-detected, so a held level draws only once.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      req_s <= 1'b0;
      req_q <= 1'b0;
    end else begin
      req_s <= request_card_i;
      req_q <= req_s;
    end
  end

  assign req_edge = req_s & ~req_q;

  // Fold the 4-bit LFSR nibble into a rank index 0..12.
  assign r_raw = lfsr[3:0];
  assign r_mod = (r_raw >= 4'd13) ? r_raw - 4'd13 : r_raw;

  assign deck_empty_o = (cards_left_o == '0);

  // Draw FSM with shoe bookkeeping and registered card/strobe outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state          <= IDLE;
      idx            <= 4'd0;
      card_to_send_o <= '0;
      card_valid_o   <= 1'b0;
      busy_o         <= 1'b0;
      cards_left_o   <= FULL_SHOE;
      for (int i = 0; i < 13; i++) count[i] <= PER_RANK;
    end else begin
      card_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (shuffle_i) begin
            cards_left_o <= FULL_SHOE;
            for (int i = 0; i < 13; i++) count[i] <= PER_RANK;
          end else if (req_edge && (cards_left_o != '0)) begin
            state  <= SAMPLE;
            busy_o <= 1'b1;
          end
        end
        SAMPLE: begin
          if (count[r_mod] != '0) begin
            idx   <= r_mod;
            state <= DEAL;
          end else begin
            idx   <= next_rank(r_mod);
            state <= PROBE;
          end
        end
        PROBE: begin
          if (count[idx] != '0) state <= DEAL;
          else                  idx   <= next_rank(idx);
        end
        DEAL: begin
          if (count[idx] != '0) begin
            count[idx]   <= count[idx] - RANK_W'(1);
            cards_left_o <= cards_left_o - CNT_W'(1);
          end
          card_to_send_o <= CARD_W'(idx + 4'd1);
          card_valid_o   <= 1'b1;
          busy_o         <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Total of the per-rank counters, used only by the bookkeeping check below.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < 13; i++) sum_c = sum_c + CNT_W'(count[i]);
  end

  // The remaining-card count must always match the per-rank counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) assert (sum_c == cards_left_o);
  end

endmodule

// File: tb/tb_seed_random_deck_dealer.sv
// Scoreboard bench: a 1-deck and an 8-deck dealer share stimulus; a shoe model predicts each deal.
module tb_seed_random_deck_dealer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic       shuf;
  logic [7:0] card_a, card_b;
  logic       valid_a, valid_b, busy_a, busy_b, empty_a, empty_b;
  logic [5:0] left_a;
  logic [8:0] left_b;

  always #5 clk = ~clk;

  seed_random_deck_dealer #(.NUM_DECKS(1)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .request_card_i(req), .shuffle_i(shuf),
    .card_to_send_o(card_a), .card_valid_o(valid_a), .busy_o(busy_a),
    .deck_empty_o(empty_a), .cards_left_o(left_a));

  seed_random_deck_dealer #(.NUM_DECKS(8)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .request_card_i(req), .shuffle_i(shuf),
    .card_to_send_o(card_b), .card_valid_o(valid_b), .busy_o(busy_b),
    .deck_empty_o(empty_b), .cards_left_o(left_b));

  typedef struct {
    int rank;
    int due;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  int         cnt[2][13];
  int         tally[2][13];
  int         left[2];
  int         decks[2] = '{1, 8};
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference LFSR and cycle counter, both advancing on every rising edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refill(input int k);
    for (int r = 0; r < 13; r++) begin
      cnt[k][r]   = 4 * decks[k];
      tally[k][r] = 0;
    end
    left[k] = 52 * decks[k];
  endtask

  function automatic int ranks_present(input int k);
    int n = 0;
    for (int r = 0; r < 13; r++) if (cnt[k][r] > 0) n++;
    return n;
  endfunction

  task automatic mon(input int k, input int v, input int card);
    exp_t e;
    int   sz;
    sz = (k == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      chk($sformatf("spurious_valid[%0d]", k), v, 0);
    end else begin
      if (k == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("rank[%0d]", k), card, e.rank);
      chk($sformatf("latency[%0d]", k), cyc, e.due);
      if (card >= 1 && card <= 13) tally[k][card-1]++;
    end
  endtask

  // Monitor: every valid strobe is matched against the oldest expected deal.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_a) mon(0, int'(valid_a), int'(card_a));
      if (valid_b) mon(1, int'(valid_b), int'(card_b));
    end
  end

  task automatic check_status(input string tag);
    chk({tag, "_left[0]"},  int'(left_a),  left[0]);
    chk({tag, "_left[1]"},  int'(left_b),  left[1]);
    chk({tag, "_empty[0]"}, int'(empty_a), int'(left[0] == 0));
    chk({tag, "_empty[1]"}, int'(empty_b), int'(left[1] == 0));
    chk({tag, "_busy[0]"},  int'(busy_a),  0);
    chk({tag, "_busy[1]"},  int'(busy_b),  0);
  endtask

  // One request of `hold` cycles. shuf_off: 0 none, 1 shuffle with the edge, 2 shuffle while busy.
  task automatic draw(input int hold, input int shuf_off);
    logic [15:0] l;
    int          r, d, idx, wait_n;
    int          busy_seen[2];
    bit          pushed[2];
    exp_t        e;
    req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (hold <= 1) req = 1'b0;
    if (shuf_off == 1) shuf = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (hold <= 2) req = 1'b0;
    shuf = 1'b0;
    l = m_lfsr;
    if (shuf_off == 2) shuf = 1'b1;
    for (int k = 0; k < 2; k++) begin
      pushed[k]    = 1'b0;
      busy_seen[k] = 0;
      if (shuf_off == 1) begin
        refill(k);
      end else if (left[k] > 0) begin
        r = int'(l[3:0]);
        if (r >= 13) r = r - 13;
        d = 0;
        while (cnt[k][(r + d) % 13] == 0) d++;
        idx = (r + d) % 13;
        cnt[k][idx]--;
        left[k]--;
        e.rank = idx + 1;
        e.due  = cyc + 2 + d;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
        pushed[k] = 1'b1;
      end
    end
    wait_n = (hold > 16) ? hold : 16;
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk);
      shuf = 1'b0;
      if (i + 3 >= hold) req = 1'b0;
      if (busy_a) busy_seen[0] = 1;
      if (busy_b) busy_seen[1] = 1;
    end
    for (int k = 0; k < 2; k++)
      if (!pushed[k]) chk($sformatf("no_draw_busy[%0d]", k), busy_seen[k], 0);
    check_status("post_draw");
  endtask

  // Request, then reset while the draw is still in flight.
  task automatic draw_reset();
    req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    refill(0);
    refill(1);
    repeat (16) @(negedge clk);
    check_status("mid_reset");
    chk("mid_reset_card[0]", int'(card_a), 0);
    chk("mid_reset_card[1]", int'(card_b), 0);
  endtask

  initial begin
    int g;
    rst_n = 1'b0;
    req   = 1'b0;
    shuf  = 1'b0;
    refill(0);
    refill(1);
    repeat (3) @(negedge clk);
    chk("reset_card[0]",  int'(card_a),  0);
    chk("reset_card[1]",  int'(card_b),  0);
    chk("reset_valid[0]", int'(valid_a), 0);
    chk("reset_valid[1]", int'(valid_b), 0);
    check_status("reset");
    rst_n = 1'b1;

    repeat ($urandom_range(1, 20)) @(negedge clk);
    draw(20, 0);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      draw($urandom_range(1, 3), 0);
    end
    draw(1, 1);
    draw(1, 2);

    // Deal down the 1-deck shoe until a single rank remains, then abort a draw with reset.
    g = 0;
    while (ranks_present(0) > 1 && g < 60) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      draw($urandom_range(1, 4), 0);
      g++;
    end
    draw_reset();

    // Empty both shoes; the 1-deck shoe keeps receiving requests after it runs dry.
    g = 0;
    while ((left[0] > 0 || left[1] > 0) && g < 600) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      draw($urandom_range(1, 4), 0);
      g++;
    end
    draw(1, 0);

    for (int r = 0; r < 13; r++) begin
      chk($sformatf("dealt_rank%0d[0]", r + 1), tally[0][r], 4);
      chk($sformatf("dealt_rank%0d[1]", r + 1), tally[1][r], 32);
    end
    chk("pending[0]", q0.size(), 0);
    chk("pending[1]", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
